// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit (HI/LO owner).
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULTU = 3'b001,
        OP_MULT  = 3'b010,
        OP_DIVU  = 3'b011,
        OP_DIV   = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
// Combinational, zero latency; no flow control.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Partial remainder is always below the divisor, so the trial fits in WIDTH+1 bits
    // and its top bit is a clean borrow flag.
    assign shifted  = {rem, dvd_bit};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO write in one edge.
// Latency 34 edges (MUL is iterations+2 when MULDIV_EARLY_OUT_EN is defined); start ignored while busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER_COUNT + 1);

    muldiv_state_t      state;
    muldiv_op_t         cmd;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   a_keep;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic               is_div;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0]   mpl_next;
    logic               last_iter;
    logic               mul_exit;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign cmd       = muldiv_op_t'(op);
    assign busy      = (state != ST_IDLE);
    assign signed_op = (cmd == OP_MULT) || (cmd == OP_DIV);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    assign mul_acc_next = opb[0] ? acc + mcand : acc;
    assign mpl_next     = opb >> 1;
    assign last_iter    = (cnt == CW'(ITER_COUNT - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_exit = last_iter || (mpl_next == '0);
`else
    assign mul_exit = last_iter;
`endif

    // Upper half of acc is the partial remainder, lower half shifts dividend out and quotient in.
    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .dvd_bit  (acc[WIDTH-1]),
        .divisor  (opb),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        prod   = neg_q ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            if (div_zero) begin
                fix_hi = a_keep;
                fix_lo = DIV0_LO[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            opb      <= '0;
            a_keep   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (clk_enable) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (cmd)
                            OP_MULTU, OP_MULT: begin
                                state  <= ST_MUL;
                                cnt    <= '0;
                                acc    <= '0;
                                mcand  <= {{WIDTH{1'b0}}, a_mag};
                                opb    <= b_mag;
                                neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r  <= 1'b0;
                                is_div <= 1'b0;
                            end
                            OP_DIVU, OP_DIV: begin
                                state    <= ST_DIV;
                                cnt      <= '0;
                                acc      <= {{WIDTH{1'b0}}, a_mag};
                                opb      <= b_mag;
                                a_keep   <= a;
                                div_zero <= (b == '0);
                                neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r    <= signed_op & a[WIDTH-1];
                                is_div   <= 1'b1;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    acc   <= mul_acc_next;
                    mcand <= mcand << 1;
                    opb   <= mpl_next;
                    cnt   <= cnt + 1'b1;
                    if (mul_exit) state <= ST_FIX;
                end
                ST_DIV: begin
                    acc <= {rem_next, acc[WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (last_iter) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases then randomized ops with random clk_enable gaps.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stamp;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    bit          en_at_edge = 1'b0;
    bit          prev_done = 1'b0;
    bit          rand_en = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic and language division semantics.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        longint      p;
        logic [63:0] up;
        int          sx;
        int          sy;
        logic [31:0] mag;
        int          it;
        r.hi = '0; r.lo = '0; r.stamp = 0; r.lat = 34;
        case (o)
            3'd1: begin up = {32'd0, x} * {32'd0, y}; r.hi = up[63:32]; r.lo = up[31:0]; end
            3'd2: begin
                p = longint'($signed(x)) * longint'($signed(y));
                up = p; r.hi = up[63:32]; r.lo = up[31:0];
            end
            3'd3: begin
                if (y == 0) begin r.hi = x; r.lo = 32'hFFFF_FFFF; end
                else begin r.lo = x / y; r.hi = x % y; end
            end
            3'd4: begin
                sx = $signed(x); sy = $signed(y);
                if (y == 0) begin r.hi = x; r.lo = 32'hFFFF_FFFF; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r.lo = x; r.hi = 0; end
                else begin r.lo = sx / sy; r.hi = sx % sy; end
            end
            default: ;
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (o == 3'd1 || o == 3'd2) begin
            mag = (o == 3'd2 && y[31]) ? -y : y;
            it = 0;
            while (mag != 0) begin it++; mag = mag >> 1; end
            if (it == 0) it = 1;
            r.lat = it + 2;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) begin
        en_at_edge = clk_enable || reset;
        if (clk_enable && !reset) edge_cnt++;
    end

    // Monitor: hold check while busy, pop-and-compare on each new done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (prev_done && en_at_edge) chk("done_pulse", done, 0);
        if (busy === 1'b1) begin
            chk("hold_hi", hi, m_hi);
            chk("hold_lo", lo, m_lo);
        end
        if (done === 1'b1 && !(prev_done && !en_at_edge)) begin
            chk("busy_at_done", busy, 0);
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("res_hi", hi, e.hi);
                chk("res_lo", lo, e.lo);
                chk("latency", edge_cnt - e.stamp + 1, e.lat);
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        if (rand_en) clk_enable = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   g = 0;
        tick();
        while (busy && g < 500) begin tick(); g++; end
        if (busy) begin chk("idle_timeout", 1, 0); return; end
        clk_enable = 1'b1;
        start = 1'b1; op = o; a = x; b = y;
        if (o >= 3'd1 && o <= 3'd4) begin
            e = model(o, x, y);
            e.stamp = edge_cnt + 1;
            sb.push_back(e);
        end
        tick();
        start = 1'b0; op = 3'd0;
        if (o == 3'd5) m_hi = x;
        if (o == 3'd6) m_lo = x;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 2000) begin @(negedge clk); #1; g++; end
        if (g >= 2000) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;

        issue(3'd2, 32'hFFFF_FFFD, 32'd7);           drain();
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFEB);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   drain();
        issue(3'd1, 32'd3, 32'd5);                   drain();
        chk("multu_small_lo", lo, 32'd15);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);           drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);   drain();
        issue(3'd3, 32'd100, 32'd0);                 drain();
        chk("divu0_hi", hi, 32'h64);
        issue(3'd4, 32'hFFFF_FFFB, 32'd0);           drain();

        issue(3'd5, 32'h1234, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", busy, 0);

        issue(3'd1, 32'h0001_0001, 32'h0000_0300);
        tick(); start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
        tick(); start = 1'b0; op = 3'd0;
        chk("mtlo_ignored", lo, m_lo);
        drain();
        chk("lo_after_mul", lo, 32'h0300_0300);

        issue(3'd4, 32'h1234_5678, 32'h0000_0123);
        repeat (9) tick();
        reset = 1'b1;
        sb.delete();
        tick();
        m_hi = '0; m_lo = '0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        reset = 1'b0;
        repeat (40) tick();

        issue(3'd2, 32'h8000_0000, 32'h8000_0000);
        repeat (5) tick();
        clk_enable = 1'b0;
        repeat (5) tick();
        chk("busy_frozen", busy, 1);
        clk_enable = 1'b1;
        drain();
        chk("pause_hi", hi, 32'h4000_0000);

        rand_en = 1'b1;
        repeat (60) issue(3'($urandom_range(0, 7)), pick(), pick());
        rand_en = 1'b0;
        clk_enable = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
